// File: rtl/reg_file_master.sv
// reg_file_master: command FSM driving an external register file (WRITE / READ / FILL / NOP).
// Optional readback check after WRITE is compiled in with macro RF_VERIFY_EN.
`default_nettype none

module reg_file_master #(
   parameter int word_size  = 8,
   parameter int index_size = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic [index_size-1:0] addr,
   input  logic [index_size-1:0] len,
   input  logic [word_size-1:0]  wdata,
   input  logic [word_size-1:0]  rf_data,
   output logic                  loadReg,
   output logic [index_size-1:0] regAdd,
   output logic [word_size-1:0]  data_in,
   output logic [word_size-1:0]  rdata,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_WRITE  = 3'd1;
   localparam logic [2:0] c_READ   = 3'd2;
   localparam logic [2:0] c_FILL   = 3'd3;
   localparam logic [2:0] c_DONE   = 3'd5;
`ifdef RF_VERIFY_EN
   localparam logic [2:0] c_VERIFY = 3'd4;
`endif

   localparam logic [1:0] c_OP_WRITE = 2'b00;
   localparam logic [1:0] c_OP_READ  = 2'b01;
   localparam logic [1:0] c_OP_FILL  = 2'b10;

   logic [2:0]            r_state;
   logic [2:0]            w_next;
   logic [1:0]            r_op;
   logic [index_size-1:0] r_addr;
   logic [index_size-1:0] r_len;
   logic [index_size-1:0] r_cnt;
   logic [word_size-1:0]  r_wdata;
   logic [word_size-1:0]  r_rdata;
   logic                  w_load;

   always_ff @(posedge clk) begin
      if (rst) r_state <= c_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         c_IDLE: begin
            if (start) begin
               case (op)
                  c_OP_WRITE: w_next = c_WRITE;
                  c_OP_READ:  w_next = c_READ;
                  c_OP_FILL:  w_next = c_FILL;
                  default:    w_next = c_DONE;
               endcase
            end
         end
`ifdef RF_VERIFY_EN
         c_WRITE:  w_next = c_VERIFY;
         c_VERIFY: w_next = c_DONE;
`else
         c_WRITE:  w_next = c_DONE;
`endif
         c_READ:   w_next = c_DONE;
         c_FILL:   w_next = (r_cnt == r_len) ? c_DONE : c_FILL;
         default:  w_next = c_IDLE;
      endcase
   end

   always_comb begin
      w_load  = 1'b0;
      regAdd  = r_addr;
      data_in = '0;
      busy    = 1'b0;
      done    = 1'b0;
      case (r_state)
         c_IDLE: ;
         c_DONE: done = 1'b1;
         c_WRITE: begin
            w_load  = 1'b1;
            data_in = r_wdata;
            busy    = 1'b1;
         end
         c_FILL: begin
            w_load  = 1'b1;
            regAdd  = r_addr + r_cnt;
            data_in = r_wdata;
            busy    = 1'b1;
         end
         default: busy = 1'b1;
      endcase
   end

   // Reset gates the write strobe so the reset edge never commits a write.
   assign loadReg = w_load & ~rst;
   assign rdata   = r_rdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= '0;
         r_addr  <= '0;
         r_len   <= '0;
         r_wdata <= '0;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else begin
         if (r_state == c_IDLE && start) begin
            r_op    <= op;
            r_addr  <= addr;
            r_len   <= len;
            r_wdata <= wdata;
            r_cnt   <= '0;
         end else if (r_state == c_FILL) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == c_READ) r_rdata <= rf_data;
      end
   end

`ifdef RF_VERIFY_EN
   logic r_err;
   always_ff @(posedge clk) begin
      if (rst)                                          r_err <= 1'b0;
      else if (r_state == c_VERIFY && rf_data != r_wdata) r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   // Latched opcode is kept for observability of the accepted command.
   logic w_unused;
   assign w_unused = ^r_op;

endmodule

`default_nettype wire
